// File: rtl/hub75_pkg.sv
// Shared defaults, colour/pixel types and the one-hot stream state encoding
// for the HUB75 receive path.
package hub75_pkg;

    localparam int COLS_DEF      = 64;
    localparam int ADDR_BITS_DEF = 5;

    typedef struct packed {
        logic b;
        logic g;
        logic r;
    } rgb3_t;

    // One shifted column: bottom-half colour above top-half colour
    typedef struct packed {
        rgb3_t rgb1;
        rgb3_t rgb0;
    } colpair_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_TOP  = 3'b010,
        S_BOT  = 3'b100
    } state_t;

endpackage

// File: rtl/hub75_sync.sv
// 2-FF synchronizer for asynchronous panel pins, with one extra delay stage
// and a registered rising-edge detector.
module hub75_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] level_o,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;
    logic [W-1:0] dly_q;
    logic [W-1:0] rise_q;

    // level_o is taken one stage past the synchronizer so it lines up with rise_o
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
            dly_q  <= '0;
            rise_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
            rise_q <= sync_q & ~dly_q;
        end
    end

    assign level_o = dly_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/hub75_receiver.sv
// HUB75 receiver: rebuilds shifted rows from the panel pins and streams each
// committed row as pixel writes. Define HUB75_RX_STATS_EN for row/frame/drop counters.
module hub75_receiver
    import hub75_pkg::*;
#(
    parameter int COLS      = COLS_DEF,
    parameter int ADDR_BITS = ADDR_BITS_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              hub_rgb0,
    input  logic [2:0]              hub_rgb1,
    input  logic [ADDR_BITS-1:0]    hub_addr,
    input  logic                    hub_blank,
    input  logic                    hub_latch,
    input  logic                    hub_sclk,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic [$clog2(COLS)-1:0] pix_x,
    output logic [ADDR_BITS:0]      pix_y,
    output logic [2:0]              pix_rgb,
    output logic                    frame_start,
    output logic                    blank,
    output logic                    overrun,
    output logic                    len_err
`ifdef HUB75_RX_STATS_EN
    ,
    output logic [15:0]             rows_rx,
    output logic [15:0]             frames_rx,
    output logic [7:0]              drops
`endif
);

    localparam int XW = $clog2(COLS);
    localparam int CW = XW + 1;
    localparam int DW = 7 + ADDR_BITS;

    logic [1:0]           ctl_level, ctl_rise;
    logic [DW-1:0]        data_level, data_rise;
    logic                 sclk_rise, latch_rise, commit;
    rgb3_t                rgb0_s, rgb1_s;
    logic [ADDR_BITS-1:0] addr_s;
    logic                 unused_sync;

    hub75_sync #(.W(2)) u_ctl_sync (
        .clk     (clk),
        .reset   (reset),
        .d_i     ({hub_latch, hub_sclk}),
        .level_o (ctl_level),
        .rise_o  (ctl_rise)
    );

    hub75_sync #(.W(DW)) u_data_sync (
        .clk     (clk),
        .reset   (reset),
        .d_i     ({hub_blank, hub_addr, hub_rgb1, hub_rgb0}),
        .level_o (data_level),
        .rise_o  (data_rise)
    );

    assign unused_sync = ^{ctl_level, data_rise};
    assign sclk_rise   = ctl_rise[0];
    assign latch_rise  = ctl_rise[1];
    assign rgb0_s      = rgb3_t'(data_level[2:0]);
    assign rgb1_s      = rgb3_t'(data_level[5:3]);
    assign addr_s      = data_level[6 +: ADDR_BITS];
    assign blank       = data_level[DW-1];

    state_t               state_q;
    logic [CW-1:0]        col_q;
    logic [ADDR_BITS-1:0] row_addr_q;
    logic                 overrun_q, len_err_q;
    colpair_t             shift_mem [COLS];
    colpair_t             held_q    [COLS];
    logic                 wr_en;
    logic [XW-1:0]        wr_idx;

    assign commit = latch_rise && (state_q == S_IDLE);
    // A latch on the same cycle as an sclk rise restarts the row, so that edge lands in column 0
    assign wr_en  = sclk_rise && (latch_rise || (col_q != CW'(COLS)));
    assign wr_idx = latch_rise ? '0 : col_q[XW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q      <= '0;
            row_addr_q <= '0;
            overrun_q  <= 1'b0;
            len_err_q  <= 1'b0;
        end else if (latch_rise) begin
            if (col_q != CW'(COLS)) len_err_q <= 1'b1;
            if (commit) row_addr_q <= addr_s;
            else        overrun_q  <= 1'b1;
            col_q <= sclk_rise ? CW'(1) : '0;
        end else if (sclk_rise && (col_q != CW'(COLS))) begin
            col_q <= col_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)  shift_mem[wr_idx] <= colpair_t'({rgb1_s, rgb0_s});
        if (commit) held_q <= shift_mem;
    end

    logic          pix_valid_q, frame_start_q;
    logic [XW-1:0] pix_x_q, x_d;
    logic [ADDR_BITS:0] pix_y_q;
    rgb3_t         pix_rgb_q;
    logic          accept, last_x;

    assign accept = pix_valid_q && pix_ready;
    assign last_x = (pix_x_q == XW'(COLS - 1));
    assign x_d    = pix_x_q + XW'(1);

    // The first pixel is read straight from shift_mem since held_q loads on this same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_rgb_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= commit && (addr_s == '0);
            unique case (state_q)
                S_IDLE: if (commit) begin
                    state_q     <= S_TOP;
                    pix_valid_q <= 1'b1;
                    pix_x_q     <= '0;
                    pix_y_q     <= {1'b0, addr_s};
                    pix_rgb_q   <= shift_mem[0].rgb0;
                end
                S_TOP: if (accept) begin
                    if (last_x) begin
                        state_q   <= S_BOT;
                        pix_x_q   <= '0;
                        pix_y_q   <= {1'b1, row_addr_q};
                        pix_rgb_q <= held_q[0].rgb1;
                    end else begin
                        pix_x_q   <= x_d;
                        pix_rgb_q <= held_q[x_d].rgb0;
                    end
                end
                S_BOT: if (accept) begin
                    if (last_x) begin
                        state_q     <= S_IDLE;
                        pix_valid_q <= 1'b0;
                    end else begin
                        pix_x_q   <= x_d;
                        pix_rgb_q <= held_q[x_d].rgb1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    pix_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_rgb     = pix_rgb_q;
    assign frame_start = frame_start_q;
    assign overrun     = overrun_q;
    assign len_err     = len_err_q;

`ifdef HUB75_RX_STATS_EN
    logic [15:0] rows_q, frames_q;
    logic [7:0]  drops_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rows_q   <= '0;
            frames_q <= '0;
            drops_q  <= '0;
        end else begin
            if (commit) rows_q <= rows_q + 16'd1;
            if (commit && (addr_s == '0)) frames_q <= frames_q + 16'd1;
            if (latch_rise && !commit && (drops_q != 8'hFF)) drops_q <= drops_q + 8'd1;
        end
    end

    assign rows_rx   = rows_q;
    assign frames_rx = frames_q;
    assign drops     = drops_q;
`endif

endmodule

// File: tb/tb_hub75_receiver.sv
// Directed bench for hub75_receiver: drives panel pins, models the shift row and
// checks every presented pixel against a scoreboard of expected writes.
module tb_hub75_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] hub_rgb0, hub_rgb1;
    logic [4:0] hub_addr;
    logic       hub_blank, hub_latch, hub_sclk;
    logic       pix_valid, pix_ready;
    logic [5:0] pix_x;
    logic [5:0] pix_y;
    logic [2:0] pix_rgb;
    logic       frame_start, blank, overrun, len_err;

    int checks = 0;
    int failures = 0;
    int writeCount = 0;
    int frameCount = 0;

    logic [14:0] expQ [$];
    logic [5:0]  modelMem [64];
    int          modelCol = 0;
    logic [14:0] expPix;

    hub75_receiver dut (
        .clk         (clk),
        .reset       (reset),
        .hub_rgb0    (hub_rgb0),
        .hub_rgb1    (hub_rgb1),
        .hub_addr    (hub_addr),
        .hub_blank   (hub_blank),
        .hub_latch   (hub_latch),
        .hub_sclk    (hub_sclk),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_rgb     (pix_rgb),
        .frame_start (frame_start),
        .blank       (blank),
        .overrun     (overrun),
        .len_err     (len_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One sclk pulse carrying a column; the model stores it the same way the panel would
    task automatic applyStimulus(input logic [2:0] r0, input logic [2:0] r1);
        hub_sclk = 1'b0;
        hub_rgb0 = r0;
        hub_rgb1 = r1;
        tick(2);
        hub_sclk = 1'b1;
        tick(2);
        if (modelCol < 64) begin
            modelMem[modelCol] = {r1, r0};
            modelCol++;
        end
    endtask

    task automatic latchRow(input logic [4:0] addr, input bit expectCommit);
        hub_addr  = addr;
        hub_sclk  = 1'b0;
        hub_latch = 1'b1;
        if (expectCommit) begin
            for (int x = 0; x < 64; x++) begin
                logic [5:0] xv;
                xv = 6'(x);
                expQ.push_back({xv, 1'b0, addr, modelMem[x][2:0]});
            end
            for (int x = 0; x < 64; x++) begin
                logic [5:0] xv;
                xv = 6'(x);
                expQ.push_back({xv, 1'b1, addr, modelMem[x][5:3]});
            end
        end
        modelCol = 0;
        tick(2);
        hub_latch = 1'b0;
        tick(2);
    endtask

    task automatic shiftRandomRow(input int n);
        for (int i = 0; i < n; i++) applyStimulus(3'($urandom), 3'($urandom));
    endtask

    task automatic waitDrain(input bit toggle, input int budget);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < budget) begin
            tick(1);
            n++;
            if (toggle && (n % 3 == 0)) pix_ready = ~pix_ready;
        end
        checkOutput("drain_timeout", expQ.size(), 0);
        expQ.delete();
        pix_ready = 1'b1;
        tick(2);
    endtask

    // Scoreboard monitor: the presented pixel must always be the next expected write
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_start) frameCount++;
            if (pix_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_pixel", {pix_x, pix_y, pix_rgb}, 32'h7FFF_FFFF);
                end else begin
                    expPix = expQ[0];
                    checkOutput("pixel_xyrgb", {pix_x, pix_y, pix_rgb}, expPix);
                    if (pix_ready) begin
                        void'(expQ.pop_front());
                        writeCount++;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w0, f0;
        reset     = 1'b1;
        hub_rgb0  = '0;
        hub_rgb1  = '0;
        hub_addr  = '0;
        hub_blank = 1'b0;
        hub_latch = 1'b0;
        hub_sclk  = 1'b0;
        pix_ready = 1'b1;
        for (int i = 0; i < 64; i++) modelMem[i] = '0;
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_pix_valid", pix_valid, 0);
        checkOutput("reset_pix_xyrgb", {pix_x, pix_y, pix_rgb}, 0);
        checkOutput("reset_frame_start", frame_start, 0);
        checkOutput("reset_flags", {overrun, len_err, blank}, 0);

        hub_blank = 1'b1;
        tick(5);
        checkOutput("blank_high", blank, 1);
        hub_blank = 1'b0;
        tick(5);
        checkOutput("blank_low", blank, 0);

        // Gradient row at addr 5
        w0 = writeCount;
        f0 = frameCount;
        for (int x = 0; x < 64; x++) applyStimulus(3'(x), ~3'(x));
        latchRow(5'd5, 1'b1);
        waitDrain(1'b0, 400);
        checkOutput("gradient_writes", writeCount - w0, 128);
        checkOutput("gradient_len_err", len_err, 0);
        checkOutput("gradient_overrun", overrun, 0);
        checkOutput("gradient_no_frame", frameCount - f0, 0);

        // Short row: last four columns keep the gradient data
        w0 = writeCount;
        shiftRandomRow(60);
        latchRow(5'd6, 1'b1);
        waitDrain(1'b0, 400);
        checkOutput("short_writes", writeCount - w0, 128);
        checkOutput("short_len_err", len_err, 1);

        // Backpressure
        w0 = writeCount;
        shiftRandomRow(64);
        latchRow(5'd12, 1'b1);
        waitDrain(1'b1, 1200);
        checkOutput("bp_writes", writeCount - w0, 128);

        // Overrun: second latch lands inside the stream and is dropped
        w0 = writeCount;
        shiftRandomRow(64);
        latchRow(5'd9, 1'b1);
        tick(6);
        checkOutput("ovr_streaming", pix_valid, 1);
        latchRow(5'd20, 1'b0);
        waitDrain(1'b0, 400);
        checkOutput("ovr_writes", writeCount - w0, 128);
        checkOutput("ovr_flag", overrun, 1);
        w0 = writeCount;
        shiftRandomRow(64);
        latchRow(5'd10, 1'b1);
        waitDrain(1'b0, 400);
        checkOutput("ovr_next_row_writes", writeCount - w0, 128);

        // Full frame
        w0 = writeCount;
        f0 = frameCount;
        for (int a = 0; a < 32; a++) begin
            shiftRandomRow(64);
            waitDrain(1'b0, 400);
            latchRow(5'(a), 1'b1);
        end
        waitDrain(1'b0, 400);
        checkOutput("frame_writes", writeCount - w0, 4096);
        checkOutput("frame_start_count", frameCount - f0, 1);

        // Reset in the middle of a stream
        shiftRandomRow(64);
        latchRow(5'd3, 1'b1);
        tick(20);
        checkOutput("mid_reset_streaming", pix_valid, 1);
        reset = 1'b1;
        tick(1);
        expQ.delete();
        modelCol = 0;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("mid_reset_valid", pix_valid, 0);
        checkOutput("mid_reset_flags", {overrun, len_err}, 0);
        w0 = writeCount;
        shiftRandomRow(64);
        latchRow(5'd7, 1'b1);
        waitDrain(1'b0, 400);
        checkOutput("post_reset_writes", writeCount - w0, 128);
        checkOutput("post_reset_flags", {overrun, len_err}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
